// File: rtl/core_pkg.sv
// Shared RV32IM core definitions: widths, opcodes and fetch-stage types.
package core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = {25'h0, OPC_OP_IMM};

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: sync FIFO with flush, plus one reserved slot for the in-flight fetch.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    input  logic         reserve,
    input  logic         unreserve,
    output fetch_entry_t rdata,
    output logic         empty,
    output logic         reserved,
    output logic         slot_free_next
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            resv_d;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        // Flush leaves the reservation alone: the in-flight response still has to return.
        resv_d = reserve | (reserved & ~unreserve);
    end

    assign slot_free_next = ({1'b0, count_d} + (CW + 1)'(resv_d)) < (CW + 1)'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            reserved <= 1'b0;
        end else begin
            count_q  <= count_d;
            reserved <= resv_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// RV32IM fetch stage: PC, imem req/gnt/rvalid handshake, instruction buffer, redirects.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of masking them.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [6:0]      if_opcode
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_misalign
`endif
);
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic            drop_q, drop_d, trap_q, trap_d;
    logic            granted, rsp, push, pop, inflight_d, allowed, misalign;
    logic            reserved, slot_free_next, fifo_empty;
    fetch_entry_t    head, wentry;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;
    assign misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign;
    end
    assign fetch_misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign granted    = (state_q == REQ) & imem_gnt;
    assign rsp        = reserved & imem_rvalid;
    assign push       = rsp & ~drop_q & ~redirect_valid;
    assign pop        = if_valid & if_ready & ~redirect_valid;
    assign inflight_d = granted | (reserved & ~imem_rvalid);
    assign allowed    = slot_free_next & ~stall & ~inflight_d & ~trap_q;
    assign wentry     = '{pc: req_pc_q, instr: imem_rdata};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        trap_d   = trap_q;
        if (granted) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end
        if (rsp) drop_d = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ:  if (granted) state_d = WAIT;
            WAIT: if (rsp) state_d = allowed ? REQ : HOLD;
            HOLD: if (allowed) state_d = REQ;
            default: state_d = IDLE;
        endcase
        // Redirect overrides everything; a response still owed to us must be discarded.
        if (redirect_valid) begin
            drop_d = inflight_d;
            if (misalign) begin
                pc_d    = pc_q;
                trap_d  = 1'b1;
                state_d = HOLD;
            end else begin
                pc_d    = redirect_pc & ~32'h3;
                trap_d  = 1'b0;
                state_d = inflight_d ? WAIT : REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            trap_q   <= trap_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .flush         (redirect_valid),
        .push          (push),
        .wdata         (wentry),
        .pop           (pop),
        .reserve       (granted),
        .unreserve     (rsp),
        .rdata         (head),
        .empty         (fifo_empty),
        .reserved      (reserved),
        .slot_free_next(slot_free_next)
    );

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;
    assign if_valid  = ~fifo_empty;
    assign if_pc     = if_valid ? head.pc : '0;
    assign if_instr  = if_valid ? head.instr : NOP_INSTR;
    assign if_opcode = if_instr[6:0];

endmodule
